// File: rtl/unary_bitstream_decoder.sv
// rtl/unary_bitstream_decoder.sv - accumulates a 2^len-bit unary window into a scaled binary result
module unary_bitstream_decoder #(
    parameter int BITWIDTH = 8,
    parameter int BIPOLAR  = 0,
    parameter int LENW     = $clog2(BITWIDTH + 1)
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic [LENW-1:0]     iWinLen,
    input  logic                iBit,
    input  logic                iBitVld,
    output logic                oBusy,
    output logic [BITWIDTH-1:0] oResult,
    output logic                oVld,
    input  logic                iRdy
);

    localparam int CW = BITWIDTH + 1;
    localparam logic [LENW-1:0] MAX_LEN = LENW'(BITWIDTH);
    // Saturation code used when every bit in the window was a one.
    localparam logic [BITWIDTH-1:0] SAT_VAL = (BIPOLAR != 0) ?
        {1'b0, {(BITWIDTH-1){1'b1}}} : {BITWIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [BITWIDTH-1:0] result_q, result_d;

    logic [LENW-1:0]     len_clamped;
    logic [LENW-1:0]     shift_amt;
    logic [CW-1:0]       win_size;
    logic [CW-1:0]       cnt_fin;
    logic [CW-1:0]       scaled_full;
    logic [BITWIDTH-1:0] scaled;
    logic [BITWIDTH-1:0] res_val;

    // Scaling datapath: cnt_fin includes the bit presented this cycle so the
    // result is ready on the same edge that accepts the final bit.
    always_comb begin
        len_clamped = (iWinLen > MAX_LEN) ? MAX_LEN : iWinLen;
        shift_amt   = MAX_LEN - len_q;
        win_size    = CW'(1) << len_q;
        cnt_fin     = cnt_q + CW'(iBit);
        scaled_full = cnt_fin << shift_amt;
        scaled      = scaled_full[BITWIDTH-1:0];
        if (cnt_fin == win_size) begin
            res_val = SAT_VAL;
        end else if (BIPOLAR != 0) begin
            // Subtracting 2^(BITWIDTH-1) modulo 2^BITWIDTH flips the MSB.
            res_val = {~scaled[BITWIDTH-1], scaled[BITWIDTH-2:0]};
        end else begin
            res_val = scaled;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_ACCUM;
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_ACCUM: begin
                // A start pulse wins over the bit presented in the same cycle.
                if (iStart) begin
                    len_d = len_clamped;
                    cnt_d = '0;
                    cyc_d = '0;
                end else if (iBitVld) begin
                    cnt_d = cnt_fin;
                    cyc_d = cyc_q + CW'(1);
                    if (cyc_q == win_size - CW'(1)) begin
                        result_d = res_val;
                        state_d  = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (iRdy) begin
                    if (iStart) begin
                        state_d = S_ACCUM;
                        len_d   = len_clamped;
                        cnt_d   = '0;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            result_q <= result_d;
        end
    end

    assign oBusy   = (state_q == S_ACCUM);
    assign oVld    = (state_q == S_RESULT);
    assign oResult = result_q;

endmodule

// File: tb/tb_unary_bitstream_decoder.sv
// tb/tb_unary_bitstream_decoder.sv - directed bench for unary_bitstream_decoder, unipolar and bipolar
module tb_unary_bitstream_decoder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] win_len;
    logic       bit_in;
    logic       bit_vld;
    logic       rdy;

    logic       busy_u, vld_u, busy_b, vld_b;
    logic [7:0] res_u, res_b;

    int n_checks;
    int n_fail;
    int bit_idx;
    logic [7:0] sob [256];

    unary_bitstream_decoder #(.BITWIDTH(8), .BIPOLAR(0)) u_uni (
        .iClk(clk), .iRstN(rst_n), .iStart(start), .iWinLen(win_len),
        .iBit(bit_in), .iBitVld(bit_vld), .oBusy(busy_u), .oResult(res_u),
        .oVld(vld_u), .iRdy(rdy)
    );

    unary_bitstream_decoder #(.BITWIDTH(8), .BIPOLAR(1)) u_bip (
        .iClk(clk), .iRstN(rst_n), .iStart(start), .iWinLen(win_len),
        .iBit(bit_in), .iBitVld(bit_vld), .oBusy(busy_b), .oResult(res_b),
        .oVld(vld_b), .iRdy(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic bit_of(input int mode, input int idx);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (idx % 2 == 0);
            3:       return (8'h5A > sob[idx]);
            4:       return (idx % 4 != 3);
            5:       return (idx % 3 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic start_run(input logic [3:0] wl);
        @(negedge clk);
        start   = 1'b1;
        win_len = wl;
        bit_vld = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        bit_idx = 0;
    endtask

    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_in  = bit_of(mode, bit_idx);
            bit_vld = 1'b1;
            bit_idx++;
        end
        @(negedge clk);
        bit_vld = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        n_checks++;
        if ({vld_u, vld_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL ack_clears_vld: got %b expected 00", {vld_u, vld_b});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_u, vld_u, res_u, busy_b, vld_b, res_b} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 00000",
                     {busy_u, vld_u, res_u, busy_b, vld_b, res_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alternating();
        start_run(4'd8);
        feed(255, 2);
        n_checks++;
        if ({busy_u, vld_u, busy_b, vld_b} !== 4'b1010) begin
            n_fail++;
            $display("FAIL alt_before_last: got %b expected 1010", {busy_u, vld_u, busy_b, vld_b});
        end
        feed(1, 2);
        n_checks++;
        if ({busy_u, vld_u, res_u} !== {2'b01, 8'h80}) begin
            n_fail++;
            $display("FAIL alt_uni: got %h expected 180", {busy_u, vld_u, res_u});
        end
        n_checks++;
        if ({busy_b, vld_b, res_b} !== {2'b01, 8'h00}) begin
            n_fail++;
            $display("FAIL alt_bip: got %h expected 100", {busy_b, vld_b, res_b});
        end
        ack();
    endtask

    task automatic test_ones_zeros();
        start_run(4'd8);
        feed(256, 1);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'hFF, 1'b1, 8'h7F}) begin
            n_fail++;
            $display("FAIL ones_len8: got %h/%h expected ff/7f", res_u, res_b);
        end
        ack();
        start_run(4'd8);
        feed(256, 0);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h00, 1'b1, 8'h80}) begin
            n_fail++;
            $display("FAIL zeros_len8: got %h/%h expected 00/80", res_u, res_b);
        end
        ack();
    endtask

    task automatic test_len4();
        start_run(4'd4);
        feed(16, 4);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'hC0, 1'b1, 8'h40}) begin
            n_fail++;
            $display("FAIL len4_12of16: got %h/%h expected c0/40", res_u, res_b);
        end
        ack();
    endtask

    task automatic test_clamp();
        start_run(4'd15);
        feed(255, 2);
        n_checks++;
        if ({busy_u, vld_u} !== 2'b10) begin
            n_fail++;
            $display("FAIL clamp_255_bits: got %b expected 10", {busy_u, vld_u});
        end
        feed(1, 2);
        n_checks++;
        if ({busy_u, vld_u, res_u} !== {2'b01, 8'h80}) begin
            n_fail++;
            $display("FAIL clamp_result: got %h expected 180", {busy_u, vld_u, res_u});
        end
        ack();
    endtask

    task automatic test_len0();
        start_run(4'd0);
        feed(1, 1);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'hFF, 1'b1, 8'h7F}) begin
            n_fail++;
            $display("FAIL len0_one: got %h/%h expected ff/7f", res_u, res_b);
        end
        ack();
        start_run(4'd0);
        feed(1, 0);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h00, 1'b1, 8'h80}) begin
            n_fail++;
            $display("FAIL len0_zero: got %h/%h expected 00/80", res_u, res_b);
        end
        ack();
    endtask

    task automatic test_sobol();
        start_run(4'd8);
        feed(256, 3);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h5A, 1'b1, 8'hDA}) begin
            n_fail++;
            $display("FAIL sobol_5a: got %h/%h expected 5a/da", res_u, res_b);
        end
        ack();
    endtask

    task automatic test_stall_backpressure();
        start_run(4'd4);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bit_in  = bit_of(5, i);
            bit_vld = 1'b1;
            @(negedge clk);
            bit_in  = 1'b1;
            bit_vld = 1'b0;
        end
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h60, 1'b1, 8'hE0}) begin
            n_fail++;
            $display("FAIL stall_result: got %h/%h expected 60/e0", res_u, res_b);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            n_checks++;
            if ({busy_u, vld_u, res_u, vld_b, res_b} !== {2'b01, 8'h60, 1'b1, 8'hE0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got %h/%h vld %b%b expected 60/e0 vld 11",
                         i, res_u, res_b, vld_u, vld_b);
            end
        end
        @(negedge clk);
        start   = 1'b1;
        win_len = 4'd4;
        rdy     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        rdy     = 1'b0;
        n_checks++;
        if ({busy_u, vld_u, busy_b, vld_b} !== 4'b1010) begin
            n_fail++;
            $display("FAIL b2b_start: got %b expected 1010", {busy_u, vld_u, busy_b, vld_b});
        end
        feed(15, 0);
        n_checks++;
        if ({busy_u, vld_u} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_cyc_cleared: got %b expected 10", {busy_u, vld_u});
        end
        feed(1, 0);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h00, 1'b1, 8'h80}) begin
            n_fail++;
            $display("FAIL b2b_cnt_cleared: got %h/%h expected 00/80", res_u, res_b);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        start_run(4'd8);
        feed(100, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_u, vld_u, res_u, busy_b, vld_b, res_b} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 00000",
                     {busy_u, vld_u, res_u, busy_b, vld_b, res_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        feed(200, 1);
        n_checks++;
        if ({busy_u, vld_u, busy_b, vld_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_result: got %b expected 0000", {busy_u, vld_u, busy_b, vld_b});
        end
    endtask

    task automatic test_restart();
        start_run(4'd8);
        feed(50, 1);
        @(negedge clk);
        start   = 1'b1;
        bit_in  = 1'b1;
        bit_vld = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        bit_vld = 1'b0;
        bit_idx = 0;
        feed(255, 2);
        n_checks++;
        if ({busy_u, vld_u} !== 2'b10) begin
            n_fail++;
            $display("FAIL restart_255_bits: got %b expected 10", {busy_u, vld_u});
        end
        feed(1, 2);
        n_checks++;
        if ({vld_u, res_u, vld_b, res_b} !== {1'b1, 8'h80, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL restart_result: got %h/%h expected 80/00", res_u, res_b);
        end
        ack();
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_fail   = 0;
        bit_idx  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        win_len  = 4'd0;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        rdy      = 1'b0;
        // First Sobol dimension, Gray-code order.
        sob[0] = 8'h00;
        for (int i = 1; i < 256; i++) begin
            c = 0;
            while (((i - 1) >> c) & 1) c++;
            sob[i] = sob[i-1] ^ (8'h80 >> c);
        end
        test_reset();
        test_alternating();
        test_ones_zeros();
        test_len4();
        test_clamp();
        test_len0();
        test_sobol();
        test_stall_backpressure();
        test_reset_mid();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unary_bitstream_decoder.md
Name: unary_bitstream_decoder

Overview:
- Decoding end of the unary datapath: accumulates a stochastic/unary bitstream over a window of 2^len accepted bits and returns the BITWIDTH-bit binary value it encodes.
- Companion to the Sobol-based encoder (binary compared against Sobol RNG output → bitstream). Sits at the output of unary compute lanes.
- Window length is selectable per run. Results are returned on a valid/ready handshake.

Parameters:
- BITWIDTH, 8, output precision; maximum window = 2^BITWIDTH bits
- BIPOLAR, 0, 0 = unipolar (unsigned) result; 1 = bipolar (two's-complement) result
- LENW, $clog2(BITWIDTH+1), width of the window-length select

Ports:
- iClk  input  1  clock
- iRstN  input  1  asynchronous reset, active low
- iStart  input  1  start pulse; latches iWinLen, clears accumulators
- iWinLen  input  LENW  log2 of window length; values >BITWIDTH clamp to BITWIDTH
- iBit  input  1  bitstream input
- iBitVld  input  1  iBit valid; cycles with iBitVld=0 are stalls and are not counted
- oBusy  output  1  high in ACCUM
- oResult  output  BITWIDTH  decoded value, registered
- oVld  output  1  oResult valid
- iRdy  input  1  consumer accepts oResult

Behaviour:
- Interface: one clock iClk; reset iRstN is asynchronous and active-low.
- Reset state: IDLE, oBusy=0, oVld=0, oResult=0, internal counters=0.
- Internal registers:
  - cnt: BITWIDTH+1 bits, ones count
  - cyc: BITWIDTH+1 bits, accepted-bit count
  - len: latched, clamped window length
- FSM states: IDLE, ACCUM, RESULT.
- IDLE:
  - iStart=1 → ACCUM; len←clamp(iWinLen); cnt←0; cyc←0.
  - iBit and iBitVld are ignored.
- ACCUM:
  - Each cycle with iBitVld=1: cnt+=iBit, cyc+=1.
  - When the accepted bit is the 2^len-th (cyc==2^len−1 and iBitVld=1): go to RESULT. oResult is computed from the final cnt, including that last bit. oVld=1 on the next cycle, so latency is 1 cycle after the last accepted bit.
  - iStart=1 in ACCUM aborts and restarts: cnt←0, cyc←0, len re-latched. The bit presented in that cycle is discarded.
- RESULT:
  - oVld=1. oResult stays stable until oVld&&iRdy.
  - On handshake: oVld←0 and go to IDLE.
  - If iStart=1 in the same cycle as the handshake: go directly to ACCUM with counters cleared (back-to-back runs, no bubble).
  - iStart without iRdy is ignored.
- Scaling, unipolar: oResult = cnt << (BITWIDTH−len). If cnt==2^len (all ones), saturate to 2^BITWIDTH−1.
- Scaling, bipolar: oResult = (cnt << (BITWIDTH−len)) − 2^(BITWIDTH−1), two's complement. If cnt==2^len, saturate to 2^(BITWIDTH−1)−1.
- len=0: single-bit window. Unipolar → 0 or all-ones. Bipolar → −2^(BITWIDTH−1) or max positive.
- oBusy=1 exactly while in ACCUM.
- Asynchronous reset at any point, including mid-ACCUM or in RESULT with oVld=1, returns all state and outputs to their reset values immediately. No result is emitted.

Test Plan:
- BITWIDTH=8, unipolar, len=8; iBit alternates 1/0, iBitVld=1 for 256 cycles → oResult=0x80. oVld rises exactly 1 cycle after the 256th bit. oBusy falls on that same edge.
- Unipolar, len=8; all-ones stream → 0xFF (saturated); all-zeros stream → 0x00. Bipolar: all-zeros → 0x80, alternating → 0x00, all-ones → 0x7F.
- Unipolar, len=4; 12 ones in 16 bits → 0xC0. iWinLen=15 → clamped to 8; result requires exactly 256 accepted bits.
- End-to-end: iBit = (0x5A > sobolrng_core oRand), 256 cycles, len=8 → oResult=0x5A exactly.
- Insert random iBitVld=0 stalls and hold iRdy low 5 cycles after oVld → result counts only valid bits; oResult/oVld stay stable while stalled. Assert iStart together with iRdy → next run starts the next cycle with oBusy=1 and counters cleared.
- Reset mid-ACCUM after 100 bits → outputs 0, IDLE, no oVld. Separately, pulse iStart mid-ACCUM at bit 50 → count restarts and the full 2^len bits are required afterwards.
